// File: rtl/scan_sel_gen_pkg.sv
// scan_sel_gen_pkg - state type and dwell helper for the scan select generator.
package scan_sel_gen_pkg;
  `include "scan_defs.vh"

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_DRIVE = ST_DRIVE,
    S_GAP   = ST_GAP
  } state_e;

  // Terminal-count load value: dwell=0 is treated as a one-cycle dwell.
  function automatic logic [7:0] dwell_load(input logic [7:0] d);
    return (d == 8'd0) ? 8'd0 : d - 8'd1;
  endfunction
endpackage

// File: rtl/scan_sel_gen_if.sv
// scan_sel_gen_if - control/status bundle of the scan select generator.
// The mask signal exists only when SCAN_MASK_EN is defined.
interface scan_sel_gen_if;
  logic       start;
  logic       stop;
  logic       cont;
  logic [7:0] dwell;
`ifdef SCAN_MASK_EN
  logic [7:0] mask;
`endif
  logic       a;
  logic       b;
  logic       c;
  logic       en;
  logic       busy;
  logic       wrap;
  logic       done;

`ifdef SCAN_MASK_EN
  modport master (output start, stop, cont, dwell, mask,
                  input  a, b, c, en, busy, wrap, done);
  modport slave  (input  start, stop, cont, dwell, mask,
                  output a, b, c, en, busy, wrap, done);
`else
  modport master (output start, stop, cont, dwell,
                  input  a, b, c, en, busy, wrap, done);
  modport slave  (input  start, stop, cont, dwell,
                  output a, b, c, en, busy, wrap, done);
`endif
endinterface

// File: rtl/scan_defs.vh
// scan_defs.vh - shared encodings for the scan select generator.
// State codes are 2-bit values; the decoder drives 8 channels.
`ifndef SCAN_DEFS_VH
`define SCAN_DEFS_VH
localparam logic [1:0] ST_IDLE  = 2'd0;
localparam logic [1:0] ST_DRIVE = 2'd1;
localparam logic [1:0] ST_GAP   = 2'd2;
localparam int         N_CH     = 8;
`endif

// File: rtl/scan_next_ch.sv
// scan_next_ch - finds the next enabled channel after cur (wrapping, and
// returning cur itself if it is the only one enabled) and flags when no
// enabled channel lies above cur.
module scan_next_ch
  import scan_sel_gen_pkg::*;
(
  input  logic [2:0] cur,
  input  logic [7:0] mask,
  output logic [2:0] nxt,
  output logic       last
);
  logic       found;
  logic [2:0] cand;

  // Ascending circular search starting one above cur.
  always_comb begin
    nxt   = cur;
    found = 1'b0;
    cand  = cur;
    for (int k = 1; k <= N_CH; k++) begin
      cand = cur + 3'(k);
      if (!found && mask[cand]) begin
        nxt   = cand;
        found = 1'b1;
      end
    end
  end

  // Last when nothing enabled sits above the current index.
  always_comb begin
    last = 1'b1;
    for (int j = 0; j < N_CH; j++) begin
      if ((j > int'(cur)) && mask[j]) last = 1'b0;
    end
  end
endmodule

// File: rtl/scan_sel_gen.sv
// scan_sel_gen - sweeps a 3-to-8 decoder select through the enabled
// channels with a dwell period per channel and a one-cycle enable gap
// between channels. Optional macro SCAN_MASK_EN adds a per-channel mask.
//
//   state | meaning
//   IDLE  | waiting for start, en low
//   DRIVE | en high on current channel for max(dwell,1) cycles
//   GAP   | en low for one cycle, select moves to next channel
module scan_sel_gen
  import scan_sel_gen_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  scan_sel_gen_if.slave bus
);
  state_e     state, state_nx;
  logic [2:0] idx, idx_nx;
  logic [7:0] cnt, cnt_nx;
  logic [7:0] dwell_q, dwell_nx;
  logic       cont_q, cont_nx;
  logic       en_q, busy_q, wrap_q, done_q;
  logic       wrap_nx, done_nx;
  logic [7:0] mask_in, mask_lat;
  logic [2:0] nc_cur, nc_nxt;
  logic [7:0] nc_mask;
  logic       nc_last;

`ifdef SCAN_MASK_EN
  logic [7:0] mask_q, mask_nx;
  assign mask_in  = bus.mask;
  assign mask_lat = mask_q;
`else
  assign mask_in  = 8'hFF;
  assign mask_lat = 8'hFF;
`endif

  // In IDLE the search starts from 7 so it returns the lowest enabled channel.
  assign nc_cur  = (state == S_IDLE) ? 3'd7 : idx;
  assign nc_mask = (state == S_IDLE) ? mask_in : mask_lat;

  scan_next_ch u_next (
    .cur  (nc_cur),
    .mask (nc_mask),
    .nxt  (nc_nxt),
    .last (nc_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state, channel, timer and pulse decisions; stop overrides all.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt;
    dwell_nx = dwell_q;
    cont_nx  = cont_q;
    wrap_nx  = 1'b0;
    done_nx  = 1'b0;
`ifdef SCAN_MASK_EN
    mask_nx  = mask_q;
`endif
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          dwell_nx = bus.dwell;
          cont_nx  = bus.cont;
`ifdef SCAN_MASK_EN
          mask_nx  = bus.mask;
`endif
          if (mask_in == 8'h00) begin
            done_nx = 1'b1;
          end else begin
            state_nx = S_DRIVE;
            idx_nx   = nc_nxt;
            cnt_nx   = dwell_load(bus.dwell);
          end
        end
      end
      S_DRIVE: begin
        if (cnt != 8'd0) begin
          cnt_nx = cnt - 8'd1;
        end else if (nc_last && !cont_q) begin
          state_nx = S_IDLE;
          done_nx  = 1'b1;
        end else begin
          state_nx = S_GAP;
          idx_nx   = nc_nxt;
          wrap_nx  = nc_last;
        end
      end
      S_GAP: begin
        state_nx = S_DRIVE;
        cnt_nx   = dwell_load(dwell_q);
      end
      default: state_nx = S_IDLE;
    endcase
    if (bus.stop && (state != S_IDLE)) begin
      state_nx = S_IDLE;
      idx_nx   = idx;
      wrap_nx  = 1'b0;
      done_nx  = 1'b1;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx     <= 3'd0;
      cnt     <= 8'd0;
      dwell_q <= 8'd0;
      cont_q  <= 1'b0;
`ifdef SCAN_MASK_EN
      mask_q  <= 8'h00;
`endif
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      idx     <= idx_nx;
      cnt     <= cnt_nx;
      dwell_q <= dwell_nx;
      cont_q  <= cont_nx;
`ifdef SCAN_MASK_EN
      mask_q  <= mask_nx;
`endif
      en_q    <= (state_nx == S_DRIVE);
      busy_q  <= (state_nx != S_IDLE);
      wrap_q  <= wrap_nx;
      done_q  <= done_nx;
    end
  end

  assign bus.a    = idx[2];
  assign bus.b    = idx[1];
  assign bus.c    = idx[0];
  assign bus.en   = en_q;
  assign bus.busy = busy_q;
  assign bus.wrap = wrap_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_scan_sel_gen.sv
// tb_scan_sel_gen - directed and random stimulus against a sweep-list model.
module tb_scan_sel_gen;
  typedef struct packed {
    logic [2:0] idx;
    logic       en;
    logic       busy;
    logic       wrap;
    logic       done;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   cyc_n = 0;

  logic       st, sp, ct, rn;
  logic [7:0] dw, mk;

  exp_t       q[$];
  exp_t       cur, exp_v;
  logic       cont_run;
  logic [7:0] d_lat, m_lat;

  scan_sel_gen_if bus ();

  scan_sel_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", tag, cyc_n, got, want);
    end
  endtask

  // Expand one sweep of the latched parameters into per-cycle outputs.
  task automatic gen_sweep();
    int chs[$];
    int d1;
    d1 = (d_lat == 8'd0) ? 1 : int'(d_lat);
    for (int i = 0; i < 8; i++) if (m_lat[i]) chs.push_back(i);
    for (int n = 0; n < chs.size(); n++) begin
      for (int k = 0; k < d1; k++)
        q.push_back('{idx: 3'(chs[n]), en: 1'b1, busy: 1'b1, wrap: 1'b0, done: 1'b0});
      if (n < chs.size() - 1)
        q.push_back('{idx: 3'(chs[n+1]), en: 1'b0, busy: 1'b1, wrap: 1'b0, done: 1'b0});
      else if (cont_run)
        q.push_back('{idx: 3'(chs[0]), en: 1'b0, busy: 1'b1, wrap: 1'b1, done: 1'b0});
      else
        q.push_back('{idx: 3'(chs[n]), en: 1'b0, busy: 1'b0, wrap: 1'b0, done: 1'b1});
    end
  endtask

  // Expected outputs after the coming edge, given the inputs now driven.
  task automatic model_step();
    logic [7:0] m;
`ifdef SCAN_MASK_EN
    m = mk;
`else
    m = 8'hFF;
`endif
    exp_v = '{idx: cur.idx, en: 1'b0, busy: 1'b0, wrap: 1'b0, done: 1'b0};
    if (!rn) begin
      q.delete();
      cont_run = 1'b0;
      exp_v.idx = 3'd0;
    end else if (cur.busy) begin
      if (sp) begin
        q.delete();
        cont_run = 1'b0;
        exp_v.done = 1'b1;
      end else begin
        if (q.size() == 0 && cont_run) gen_sweep();
        if (q.size() != 0) exp_v = q.pop_front();
      end
    end else if (st) begin
      if (m == 8'h00) begin
        exp_v.done = 1'b1;
      end else begin
        d_lat    = dw;
        m_lat    = m;
        cont_run = ct;
        gen_sweep();
        exp_v = q.pop_front();
      end
    end
  endtask

  task automatic tick();
    exp_t obs;
    bus.start = st;
    bus.stop  = sp;
    bus.cont  = ct;
    bus.dwell = dw;
`ifdef SCAN_MASK_EN
    bus.mask  = mk;
`endif
    rst_n = rn;
    model_step();
    @(posedge clk);
    #1;
    cyc_n++;
    obs = '{idx: {bus.a, bus.b, bus.c}, en: bus.en, busy: bus.busy, wrap: bus.wrap, done: bus.done};
    chk("outputs", 32'(obs), 32'(exp_v));
    cur = exp_v;
  endtask

  task automatic quiet();
    st = 1'b0; sp = 1'b0; rn = 1'b1;
  endtask

  initial begin
    int busy_cnt, en_cnt, done_cnt, wrap_cnt;
    logic [7:0] visited;
    cur = '0;
    cont_run = 1'b0;
    d_lat = 8'd0;
    m_lat = 8'd0;
    st = 1'b0; sp = 1'b0; ct = 1'b0; dw = 8'd0; mk = 8'hFF; rn = 1'b0;

    // Reset
    tick(); tick();
    chk("rst_outs", {29'd0, bus.a, bus.b, bus.c, bus.en, bus.busy, bus.wrap, bus.done}, 32'd0);
    quiet(); tick();

    // Full single sweep, dwell 3
    busy_cnt = 0; en_cnt = 0; done_cnt = 0; visited = 8'h00;
    st = 1'b1; dw = 8'd3; ct = 1'b0; mk = 8'hFF;
    for (int i = 0; i < 60; i++) begin
      tick();
      st = 1'b0;
      if (bus.busy) busy_cnt++;
      if (bus.en) begin en_cnt++; visited[{bus.a, bus.b, bus.c}] = 1'b1; end
      if (bus.done) done_cnt++;
      if (!bus.busy) break;
    end
    chk("sweep_busy", 32'(busy_cnt), 32'd31);
    chk("sweep_en", 32'(en_cnt), 32'd24);
    chk("sweep_done", 32'(done_cnt), 32'd1);
    chk("sweep_visit", 32'(visited), 32'hFF);
    quiet(); tick(); tick();

`ifdef SCAN_MASK_EN
    // Sparse mask, continuous, dwell 0
    wrap_cnt = 0;
    st = 1'b1; dw = 8'd0; ct = 1'b1; mk = 8'b1010_0100;
    for (int i = 0; i < 12; i++) begin
      tick();
      st = 1'b0;
      if (bus.wrap) wrap_cnt++;
    end
    chk("sparse_wrap", 32'(wrap_cnt), 32'd2);
    sp = 1'b1; tick(); quiet(); tick();

    // Empty mask
    st = 1'b1; mk = 8'h00; ct = 1'b0;
    tick();
    chk("zmask_done", 32'(bus.done), 32'd1);
    chk("zmask_busy", 32'(bus.busy), 32'd0);
    quiet(); tick();
    chk("zmask_en", 32'(bus.en), 32'd0);
    mk = 8'hFF;
`endif

    // Stop during DRIVE of channel 4 together with start
    st = 1'b1; dw = 8'd2; ct = 1'b0; mk = 8'hFF;
    tick(); st = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.en && {bus.a, bus.b, bus.c} == 3'd4) break;
      tick();
    end
    chk("stop_reach", {29'd0, bus.a, bus.b, bus.c}, 32'd4);
    sp = 1'b1; st = 1'b1; dw = 8'd9;
    tick();
    chk("stop_done", 32'(bus.done), 32'd1);
    chk("stop_en", 32'(bus.en), 32'd0);
    chk("stop_busy", 32'(bus.busy), 32'd0);
    quiet(); tick();
    chk("stop_idle", 32'(bus.busy), 32'd0);

    // Start while busy with a new dwell has no effect
    busy_cnt = 0;
    st = 1'b1; dw = 8'd1; ct = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      st = (i == 2); dw = (i == 2) ? 8'd5 : 8'd1; ct = (i == 2);
      if (bus.busy) busy_cnt++;
      if (!bus.busy) break;
    end
    chk("busy_start", 32'(busy_cnt), 32'd15);
    quiet(); tick();

    // Reset mid-DRIVE
    st = 1'b1; dw = 8'd4; ct = 1'b1;
    tick(); st = 1'b0; tick(); tick();
    rn = 1'b0;
    tick();
    chk("mid_rst", {29'd0, bus.a, bus.b, bus.c, bus.en, bus.busy, bus.wrap, bus.done}, 32'd0);
    quiet(); tick();

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      st = ($urandom_range(0, 5) == 0);
      sp = cur.busy && ($urandom_range(0, 39) == 0);
      ct = $urandom_range(0, 1);
      dw = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 4));
      case ($urandom_range(0, 7))
        0:       mk = 8'h00;
        1:       mk = 8'(1 << $urandom_range(0, 7));
        default: mk = 8'($urandom);
      endcase
      rn = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
